// File: rtl/flags_reg.sv
// ---------------------------------------------------------------------------
// flags_reg - processor status-flags register.
//
// Captures the ALU flag vector on a rising clock edge when the ALU marks its
// result valid (ALU_ready). Otherwise the last captured value is held.
// Synchronous active-high reset clears the register and has priority over
// capture.
//
// Default bit map (WIDTH = 4): [0] Z zero, [1] N negative, [2] C carry,
// [3] V overflow.
//
// Ports:
//   clk          in   1      system clock, rising-edge active
//   reset        in   1      synchronous, active-high reset
//   ALU_flags    in   WIDTH  flag vector for the current ALU operation
//   ALU_ready    in   1      ALU result-valid strobe, acts as load enable
//   out          out  WIDTH  registered flag vector
//   flags_valid  out  1      (FLAGS_VALID_EN only) set by the first capture
//                            after reset, cleared by reset
//
// Optional feature macro: FLAGS_VALID_EN
// ---------------------------------------------------------------------------
module flags_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALU_flags,
    input  logic             ALU_ready,
`ifdef FLAGS_VALID_EN
    output logic             flags_valid,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_flags;
    logic             w_load;

    assign w_load = ALU_ready;

    // Reset wins over capture; flags presented in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_load) begin
            r_flags <= ALU_flags;
        end
    end

    assign out = r_flags;

`ifdef FLAGS_VALID_EN
    logic r_valid;

    // Sticky: distinguishes "zero after reset" from "ALU produced zero flags".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end
    end

    assign flags_valid = r_valid;
`endif

endmodule

// File: tb/tb_flags_reg.sv
module tb_flags_reg;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] ALU_flags;
    logic             ALU_ready;
    logic [WIDTH-1:0] out;
`ifdef FLAGS_VALID_EN
    logic             flags_valid;
`endif

    flags_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALU_flags  (ALU_flags),
        .ALU_ready  (ALU_ready),
`ifdef FLAGS_VALID_EN
        .flags_valid(flags_valid),
`endif
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] exp_out;
        logic             exp_valid;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] m_out;
    logic             m_valid;

    // Drive one cycle of stimulus, push the model's expected result, then
    // pop and compare just after the rising edge.
    task automatic step(input string tag, input logic rst, input logic rdy,
                        input logic [WIDTH-1:0] flags);
        exp_t e;
        reset     = rst;
        ALU_ready = rdy;
        ALU_flags = flags;
        if (rst) begin
            m_out   = '0;
            m_valid = 1'b0;
        end else if (rdy) begin
            m_out   = flags;
            m_valid = 1'b1;
        end
        e.tag       = tag;
        e.exp_out   = m_out;
        e.exp_valid = m_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        assert (out === e.exp_out) else begin
            n_fail++;
            $error("FAIL %s: out observed %b expected %b", e.tag, out, e.exp_out);
        end
`ifdef FLAGS_VALID_EN
        n_checks++;
        assert (flags_valid === e.exp_valid) else begin
            n_fail++;
            $error("FAIL %s_valid: flags_valid observed %b expected %b",
                   e.tag, flags_valid, e.exp_valid);
        end
`endif
    endtask

    initial begin
        reset     = 1'b0;
        ALU_ready = 1'b0;
        ALU_flags = '0;
        m_out     = 'x;
        m_valid   = 1'bx;
        #2;

        // Reset state
        step("reset_init", 1'b1, 1'b0, 4'b1111);

        // Capture then hold
        step("capture",    1'b0, 1'b1, 4'b0001);
        step("hold1",      1'b0, 1'b0, 4'b0010);
        step("hold2",      1'b0, 1'b0, 4'b0010);

        // Reset with ready low, held for two cycles
        step("rst_rdy0_a", 1'b1, 1'b0, 4'b0011);
        step("rst_rdy0_b", 1'b1, 1'b0, 4'b0011);

        // Load something non-zero, then reset must beat a concurrent capture
        step("load_pre",   1'b0, 1'b1, 4'b1111);
        step("rst_prio_a", 1'b1, 1'b1, 4'b0100);
        step("rst_prio_b", 1'b1, 1'b1, 4'b0100);

        // Back-to-back capture
        step("b2b_1",      1'b0, 1'b1, 4'b1010);
        step("b2b_2",      1'b0, 1'b1, 4'b0101);

        // Valid-flag case: capture of all-zero flags after reset
        step("rst_v",      1'b1, 1'b0, 4'b1001);
        step("zero_cap",   1'b0, 1'b1, 4'b0000);
        step("zero_hold",  1'b0, 1'b0, 4'b1110);
        step("rst_v2",     1'b1, 1'b0, 4'b0110);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            step("random", ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                 WIDTH'($urandom_range(0, 15)));
        end

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: observed %0d entries required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
